// File: rtl/sig_scan_engine_pkg.sv
// ---------------------------------------------------------------------------
// sig_scan_engine_pkg
//   Definitions shared by the signature scanner: the FSM state encoding, the
//   layout of the 256-bit output record, and the sentinel value that marks the
//   end-of-packet summary record.
//   The record struct fixes the field order and widths:
//   {pad[159:0], sig_off[31:0], sig_id[31:0], sig_cnt[31:0]}, with sig_cnt in
//   the least significant bits.
// ---------------------------------------------------------------------------
package sig_scan_engine_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT  = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_SUMMARY = 2'd2
    } scan_state_e;

    localparam int REC_W       = 256;
    localparam int REC_FIELD_W = 32;
    localparam int REC_PAD_W   = REC_W - 3 * REC_FIELD_W;

    localparam logic [REC_FIELD_W-1:0] SUMMARY_SENTINEL = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [REC_PAD_W-1:0]   pad;
        logic [REC_FIELD_W-1:0] sig_off;
        logic [REC_FIELD_W-1:0] sig_id;
        logic [REC_FIELD_W-1:0] sig_cnt;
    } scan_rec_t;

endpackage

// File: rtl/sig_scan_engine_lane_match.sv
// ---------------------------------------------------------------------------
// sig_lane_match
//   Single-lane signature detector. A lane matches when its top MAGIC_W bits
//   equal the packet magic and every byte of the lane is valid. The remaining
//   low bits of the lane are returned as the signature id.
// Ports
//   lane_data_i  in   LANE_W     lane payload
//   lane_bvld_i  in   LANE_W/8   byte valids for this lane
//   magic_i      in   MAGIC_W    magic value in force for the packet
//   match_o      out  1          lane holds a complete signature
//   sid_o        out  SID_W      signature id field (lane LSBs)
// ---------------------------------------------------------------------------
module sig_lane_match
    import sig_scan_engine_pkg::*;
#(
    parameter int LANE_W  = 32,
    parameter int MAGIC_W = 16
) (
    input  logic [LANE_W-1:0]         lane_data_i,
    input  logic [LANE_W/8-1:0]       lane_bvld_i,
    input  logic [MAGIC_W-1:0]        magic_i,
    output logic                      match_o,
    output logic [LANE_W-MAGIC_W-1:0] sid_o
);

    assign match_o = (lane_data_i[LANE_W-1 -: MAGIC_W] == magic_i) && (&lane_bvld_i);
    assign sid_o   = lane_data_i[LANE_W-MAGIC_W-1:0];

endmodule

// File: rtl/sig_scan_engine.sv
// ---------------------------------------------------------------------------
// sig_scan_engine
//   Signature scanner between the dispatcher (dpt) and the collector (clt).
//   Each accepted beat is split into LANES lanes. Matching lanes are reported
//   one record per cycle in ascending lane order. After the last beat of a
//   packet, a summary record follows that carries the total match count.
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   cfg_magic     in  MAGIC_W   magic value, sampled on the first beat of a packet
//   dpt_dvld_scn  in  1         input beat valid
//   dpt_cmd_scn   in  8         command, sampled on the first beat
//   dpt_id_scn    in  24        buffer id, sampled on the first beat
//   dpt_poff_scn  in  32        byte offset of the beat within the packet
//   dpt_data_scn  in  DATA_W    beat data, lane 0 in the LSBs
//   dpt_bvld_scn  in  DATA_W/8  byte valids
//   dpt_end_scn   in  1         last beat of the packet
//   scn_rdy_dpt   out 1         scanner can take a beat
//   scn_dvld_clt  out 1         output record valid
//   scn_cmd_clt   out 8         packet command
//   scn_id_clt    out 24        packet buffer id
//   scn_data_clt  out 256       {160'h0, sig_off, sig_id, sig_cnt}
//   scn_bvld_clt  out 32        always all-ones
//   scn_end_clt   out 1         set on the summary record only
//   clt_rdy_scn   in  1         collector ready
//   stat_pkts/stat_matches/stat_stall out 32 (only when SIG_SCAN_STATS_EN is
//   defined): counters of summary transfers, match transfers and stall cycles.
// ---------------------------------------------------------------------------
module sig_scan_engine
    import sig_scan_engine_pkg::*;
#(
    parameter int DATA_W  = 256,
    parameter int LANE_W  = 32,
    parameter int MAGIC_W = 16,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MAGIC_W-1:0]    cfg_magic,
    input  logic                  dpt_dvld_scn,
    input  logic [7:0]            dpt_cmd_scn,
    input  logic [23:0]           dpt_id_scn,
    input  logic [31:0]           dpt_poff_scn,
    input  logic [DATA_W-1:0]     dpt_data_scn,
    input  logic [DATA_W/8-1:0]   dpt_bvld_scn,
    input  logic                  dpt_end_scn,
    output logic                  scn_rdy_dpt,
    output logic                  scn_dvld_clt,
    output logic [7:0]            scn_cmd_clt,
    output logic [23:0]           scn_id_clt,
    output logic [255:0]          scn_data_clt,
    output logic [31:0]           scn_bvld_clt,
    output logic                  scn_end_clt,
`ifdef SIG_SCAN_STATS_EN
    output logic [31:0]           stat_pkts,
    output logic [31:0]           stat_matches,
    output logic [31:0]           stat_stall,
`endif
    input  logic                  clt_rdy_scn
);

    localparam int LANES = DATA_W / LANE_W;
    localparam int BV_W  = LANE_W / 8;
    localparam int SID_W = LANE_W - MAGIC_W;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    scan_state_e                  state_q, state_d;
    logic [LANES-1:0]             lane_match, match_q, match_clr;
    logic [LANES-1:0][SID_W-1:0]  lane_sid, sid_q;
    logic [31:0]                  poff_q, lsb_off;
    logic                         end_q, first_q;
    logic [MAGIC_W-1:0]           magic_q, magic_eff;
    logic [7:0]                   cmd_q;
    logic [23:0]                  id_q;
    logic [CNT_W-1:0]             cnt_q, cnt_inc;
    logic [IDX_W-1:0]             lsb_idx;
    logic                         accept, xfer;
    scan_rec_t                    rec;

    // The first beat of a packet is matched against the live cfg_magic. The
    // same value is captured for the rest of the packet.
    assign magic_eff = first_q ? cfg_magic : magic_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sig_lane_match #(
            .LANE_W  (LANE_W),
            .MAGIC_W (MAGIC_W)
        ) u_match (
            .lane_data_i (dpt_data_scn[g*LANE_W +: LANE_W]),
            .lane_bvld_i (dpt_bvld_scn[g*BV_W +: BV_W]),
            .magic_i     (magic_eff),
            .match_o     (lane_match[g]),
            .sid_o       (lane_sid[g])
        );
    end

    assign accept = dpt_dvld_scn & scn_rdy_dpt;
    assign xfer   = scn_dvld_clt & clt_rdy_scn;

    // Lowest set bit of the pending match vector. The loop runs downward so
    // that the last assignment wins and leaves the lowest index.
    always_comb begin
        lsb_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (match_q[i]) lsb_idx = IDX_W'(i);
        end
    end

    assign match_clr = match_q & ~(LANES'(1) << lsb_idx);
    assign lsb_off   = poff_q + 32'(lsb_idx) * 32'(BV_W);
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // ---------------- FSM: state register ----------------
    // NOTE: clocked processes use non-blocking assignments only, so every
    // register samples pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_ACCEPT;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCEPT: begin
                if (accept) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // An empty vector on entry leaves after one idle cycle. Otherwise,
                // the FSM leaves on the transfer that clears the last bit.
                if (match_q == '0 || (xfer && match_clr == '0))
                    state_d = end_q ? ST_SUMMARY : ST_ACCEPT;
            end
            ST_SUMMARY: begin
                if (xfer) state_d = ST_ACCEPT;
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case can infer a latch.
    always_comb begin
        scn_rdy_dpt  = 1'b0;
        scn_dvld_clt = 1'b0;
        scn_end_clt  = 1'b0;
        rec          = '0;
        case (state_q)
            ST_ACCEPT: scn_rdy_dpt = 1'b1;
            ST_DRAIN: begin
                scn_dvld_clt = |match_q;
                rec.sig_off  = lsb_off;
                rec.sig_id   = 32'(sid_q[lsb_idx]);
                rec.sig_cnt  = 32'(cnt_inc);
            end
            ST_SUMMARY: begin
                scn_dvld_clt = 1'b1;
                scn_end_clt  = 1'b1;
                rec.sig_off  = SUMMARY_SENTINEL;
                rec.sig_id   = SUMMARY_SENTINEL;
                rec.sig_cnt  = 32'(cnt_q);
            end
            default: ;
        endcase
    end

    assign scn_data_clt = rec;
    assign scn_cmd_clt  = cmd_q;
    assign scn_id_clt   = id_q;
    assign scn_bvld_clt = '1;

    // ---------------- Control / packet context ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= '0;
            end_q   <= 1'b0;
            first_q <= 1'b1;
            cnt_q   <= '0;
            magic_q <= '0;
            cmd_q   <= '0;
            id_q    <= '0;
        end else begin
            if (accept) begin
                match_q <= lane_match;
                end_q   <= dpt_end_scn;
                if (first_q) begin
                    first_q <= 1'b0;
                    magic_q <= cfg_magic;
                    cmd_q   <= dpt_cmd_scn;
                    id_q    <= dpt_id_scn;
                end
            end else if (xfer && state_q == ST_DRAIN) begin
                match_q <= match_clr;
                cnt_q   <= cnt_inc;
            end else if (xfer && state_q == ST_SUMMARY) begin
                cnt_q   <= '0;
                first_q <= 1'b1;
            end
        end
    end

    // ---------------- Beat payload ----------------
    // NOTE: the per-lane ids and the offset are only read while match_q flags
    // them as live. They therefore carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            sid_q  <= lane_sid;
            poff_q <= dpt_poff_scn;
        end
    end

`ifdef SIG_SCAN_STATS_EN
    logic [31:0] stat_pkts_q, stat_matches_q, stat_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_pkts_q    <= '0;
            stat_matches_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            if (xfer && state_q == ST_SUMMARY)  stat_pkts_q    <= stat_pkts_q + 32'd1;
            if (xfer && state_q == ST_DRAIN)    stat_matches_q <= stat_matches_q + 32'd1;
            if (scn_dvld_clt && !clt_rdy_scn)   stat_stall_q   <= stat_stall_q + 32'd1;
        end
    end

    assign stat_pkts    = stat_pkts_q;
    assign stat_matches = stat_matches_q;
    assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_sig_scan_engine.sv
// ---------------------------------------------------------------------------
// tb_sig_scan_engine
//   Self-checking bench for sig_scan_engine. Expected records are queued as
//   beats are issued. A negedge monitor compares every presented record with
//   the head of the queue. The head is popped on transfer and held while the
//   collector stalls.
// ---------------------------------------------------------------------------
module tb_sig_scan_engine;

    typedef struct {
        logic [7:0]   cmd;
        logic [23:0]  id;
        logic [255:0] data;
        logic         end_f;
    } rec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  cfg_magic;
    logic         dpt_dvld_scn;
    logic [7:0]   dpt_cmd_scn;
    logic [23:0]  dpt_id_scn;
    logic [31:0]  dpt_poff_scn;
    logic [255:0] dpt_data_scn;
    logic [31:0]  dpt_bvld_scn;
    logic         dpt_end_scn;
    logic         scn_rdy_dpt;
    logic         scn_dvld_clt;
    logic [7:0]   scn_cmd_clt;
    logic [23:0]  scn_id_clt;
    logic [255:0] scn_data_clt;
    logic [31:0]  scn_bvld_clt;
    logic         scn_end_clt;
    logic         clt_rdy_scn;
`ifdef SIG_SCAN_STATS_EN
    logic [31:0]  stat_pkts, stat_matches, stat_stall;
`endif

    sig_scan_engine dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_magic    (cfg_magic),
        .dpt_dvld_scn (dpt_dvld_scn),
        .dpt_cmd_scn  (dpt_cmd_scn),
        .dpt_id_scn   (dpt_id_scn),
        .dpt_poff_scn (dpt_poff_scn),
        .dpt_data_scn (dpt_data_scn),
        .dpt_bvld_scn (dpt_bvld_scn),
        .dpt_end_scn  (dpt_end_scn),
        .scn_rdy_dpt  (scn_rdy_dpt),
        .scn_dvld_clt (scn_dvld_clt),
        .scn_cmd_clt  (scn_cmd_clt),
        .scn_id_clt   (scn_id_clt),
        .scn_data_clt (scn_data_clt),
        .scn_bvld_clt (scn_bvld_clt),
        .scn_end_clt  (scn_end_clt),
`ifdef SIG_SCAN_STATS_EN
        .stat_pkts    (stat_pkts),
        .stat_matches (stat_matches),
        .stat_stall   (stat_stall),
`endif
        .clt_rdy_scn  (clt_rdy_scn)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    rec_t exp_q[$];

    // Reference model state: packet-level view of the scanner rules.
    logic        m_first   = 1'b1;
    logic [15:0] m_magic   = '0;
    logic [7:0]  m_cmd     = '0;
    logic [23:0] m_id      = '0;
    logic [31:0] m_cnt     = '0;
    int          m_pkts    = 0;
    int          m_matches = 0;

    // 0: always ready, 1: toggling, 2: random, 3: held low
    int rdy_mode = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    function automatic rec_t mk(input logic [7:0] c, input logic [23:0] i, input logic [31:0] off,
                                input logic [31:0] sid, input logic [31:0] cnt, input logic e);
        rec_t r;
        r.cmd   = c;
        r.id    = i;
        r.data  = {160'h0, off, sid, cnt};
        r.end_f = e;
        return r;
    endfunction

    task automatic model_reset();
        m_first   = 1'b1;
        m_cnt     = '0;
        m_pkts    = 0;
        m_matches = 0;
    endtask

    // Scanner rules applied to the beat currently on the input bus.
    task automatic model_beat();
        logic [31:0] word;
        if (m_first) begin
            m_magic = cfg_magic;
            m_cmd   = dpt_cmd_scn;
            m_id    = dpt_id_scn;
            m_first = 1'b0;
        end
        for (int l = 0; l < 8; l++) begin
            word = dpt_data_scn[l*32 +: 32];
            if (word[31:16] == m_magic && dpt_bvld_scn[l*4 +: 4] == 4'hF) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                m_matches++;
                exp_q.push_back(mk(m_cmd, m_id, dpt_poff_scn + 32'(l * 4),
                                   {16'h0, word[15:0]}, m_cnt, 1'b0));
            end
        end
        if (dpt_end_scn) begin
            exp_q.push_back(mk(m_cmd, m_id, 32'hFFFF_FFFF, 32'hFFFF_FFFF, m_cnt, 1'b1));
            m_cnt   = '0;
            m_first = 1'b1;
            m_pkts++;
        end
    endtask

    // Drives one beat and holds it until accepted. Returns at posedge+1 of the
    // accepting edge.
    task automatic send_beat(input logic [7:0] cmd, input logic [23:0] id, input logic [31:0] poff,
                             input logic [255:0] data, input logic [31:0] bvld, input logic e,
                             input bit use_model);
        int n;
        dpt_dvld_scn = 1'b1;
        dpt_cmd_scn  = cmd;
        dpt_id_scn   = id;
        dpt_poff_scn = poff;
        dpt_data_scn = data;
        dpt_bvld_scn = bvld;
        dpt_end_scn  = e;
        if (use_model) model_beat();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scn_rdy_dpt && n < 500);
        if (!scn_rdy_dpt) fail_now("beat_accept");
        @(posedge clk);
        #1;
        dpt_dvld_scn = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now(name);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] lanes8(input logic [31:0] w0, input logic [31:0] w1,
                                            input logic [31:0] w2, input logic [31:0] w3,
                                            input logic [31:0] w4, input logic [31:0] w5,
                                            input logic [31:0] w6, input logic [31:0] w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    // Collector ready generator
    initial begin
        clt_rdy_scn = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       clt_rdy_scn = 1'b1;
                1:       clt_rdy_scn = ~clt_rdy_scn;
                2:       clt_rdy_scn = 1'($urandom_range(0, 1));
                default: clt_rdy_scn = 1'b0;
            endcase
        end
    end

    // Monitor: compare any presented record with the head of the expected queue.
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            if (!reset && scn_dvld_clt) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_rec: got %0h expected no record", scn_data_clt);
                end else begin
                    e = exp_q[0];
                    check(clt_rdy_scn ? "rec_data" : "stall_data", scn_data_clt, e.data);
                    check(clt_rdy_scn ? "rec_cmd"  : "stall_cmd", 256'(scn_cmd_clt), 256'(e.cmd));
                    check(clt_rdy_scn ? "rec_id"   : "stall_id", 256'(scn_id_clt), 256'(e.id));
                    check(clt_rdy_scn ? "rec_end"  : "stall_end", 256'(scn_end_clt), 256'(e.end_f));
                    check("rec_bvld", 256'(scn_bvld_clt), 256'(32'hFFFF_FFFF));
                    if (clt_rdy_scn) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [255:0] d;
        logic [31:0]  bv;
        logic [15:0]  pool [4];
        logic [15:0]  mg;
        int           nbeats;

        reset        = 1'b1;
        cfg_magic    = 16'hDEAD;
        dpt_dvld_scn = 1'b0;
        dpt_cmd_scn  = '0;
        dpt_id_scn   = '0;
        dpt_poff_scn = '0;
        dpt_data_scn = '0;
        dpt_bvld_scn = '0;
        dpt_end_scn  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy",  256'(scn_rdy_dpt), 256'(1'b1));
        check("rst_dvld", 256'(scn_dvld_clt), 256'(1'b0));
        check("rst_end",  256'(scn_end_clt), 256'(1'b0));
        check("rst_cmd",  256'(scn_cmd_clt), 256'(8'h0));
        check("rst_id",   256'(scn_id_clt), 256'(24'h0));
        check("rst_data", scn_data_clt, 256'h0);
        check("rst_bvld", 256'(scn_bvld_clt), 256'(32'hFFFF_FFFF));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single-beat packet, lanes 2 and 5. Expectations written out by hand.
        rdy_mode = 0;
        exp_q.push_back(mk(8'h5A, 24'h123456, 32'd8,  32'h7,   32'd1, 1'b0));
        exp_q.push_back(mk(8'h5A, 24'h123456, 32'd20, 32'h100, 32'd2, 1'b0));
        exp_q.push_back(mk(8'h5A, 24'h123456, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 1'b1));
        m_pkts++;
        m_matches += 2;
        send_beat(8'h5A, 24'h123456, 32'd0,
                  lanes8(0, 0, 32'hDEAD0007, 0, 0, 32'hDEAD0100, 0, 0), '1, 1'b1, 1'b0);
        @(negedge clk);
        check("first_latency_dvld", 256'(scn_dvld_clt), 256'(1'b1));
        wait_drain("drain_t1");

        // Two beats, lane 0 in each
        send_beat(8'h11, 24'hA1, 32'd0,  lanes8(32'hDEAD0001, 0, 0, 0, 0, 0, 0, 0), '1, 1'b0, 1'b1);
        send_beat(8'h22, 24'hB2, 32'd32, lanes8(32'hDEAD0002, 0, 0, 0, 0, 0, 0, 0), '1, 1'b1, 1'b1);
        wait_drain("drain_t2");

        // No matches over three beats. Ready drops after each beat.
        for (int b = 0; b < 3; b++) begin
            send_beat(8'h33, 24'hC3, 32'(b * 32), lanes8(1, 2, 3, 4, 5, 6, 7, 8), '1, (b == 2), 1'b1);
            @(negedge clk);
            check("nomatch_rdy_drop", 256'(scn_rdy_dpt), 256'(1'b0));
        end
        wait_drain("drain_t3");

        // All eight lanes while the collector toggles ready
        rdy_mode = 1;
        for (int l = 0; l < 8; l++) d[l*32 +: 32] = {16'hDEAD, 16'(l + 16'h40)};
        send_beat(8'h44, 24'hD4, 32'd0, d, '1, 1'b1, 1'b1);
        wait_drain("drain_t4");
        rdy_mode = 0;

        // Partial byte-valid on lane 3. cfg_magic changes mid-packet.
        bv = '1;
        bv[15:12] = 4'b0111;
        send_beat(8'h55, 24'hE5, 32'd64, lanes8(0, 32'hDEAD0011, 0, 32'hDEAD0033, 0, 0, 0, 0), bv, 1'b0, 1'b1);
        cfg_magic = 16'hBEEF;
        send_beat(8'h55, 24'hE5, 32'd96, lanes8(32'hBEEF0001, 32'hDEAD0002, 0, 0, 0, 0, 0, 0), '1, 1'b1, 1'b1);
        send_beat(8'h66, 24'hF6, 32'd0, lanes8(32'hBEEF0003, 32'hDEAD0004, 0, 0, 0, 0, 0, 0), '1, 1'b1, 1'b1);
        wait_drain("drain_t5");

        // Reset while four matches are pending
        cfg_magic = 16'hDEAD;
        rdy_mode  = 3;
        send_beat(8'h77, 24'h77, 32'd0,
                  lanes8(32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004, 0, 0, 0, 0), '1, 1'b1, 1'b1);
        @(negedge clk);
        check("pre_reset_dvld", 256'(scn_dvld_clt), 256'(1'b1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("reset_dvld", 256'(scn_dvld_clt), 256'(1'b0));
        check("reset_rdy",  256'(scn_rdy_dpt), 256'(1'b1));
`ifdef SIG_SCAN_STATS_EN
        check("reset_stat_pkts",    256'(stat_pkts), 256'(32'h0));
        check("reset_stat_matches", 256'(stat_matches), 256'(32'h0));
        check("reset_stat_stall",   256'(stat_stall), 256'(32'h0));
`endif
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rdy_mode = 0;
        send_beat(8'h88, 24'h88, 32'd0, lanes8(0, 0, 0, 32'hDEAD0099, 0, 0, 0, 0), '1, 1'b1, 1'b1);
        wait_drain("drain_t6");

        // Randomised packets checked by the model
        pool[0] = 16'hDEAD;
        pool[1] = 16'hBEEF;
        pool[2] = 16'hC0DE;
        pool[3] = 16'h1234;
        rdy_mode = 2;
        for (int p = 0; p < 25; p++) begin
            nbeats = $urandom_range(1, 3);
            for (int b = 0; b < nbeats; b++) begin
                if ($urandom_range(0, 3) == 0) cfg_magic = pool[$urandom_range(0, 3)];
                for (int l = 0; l < 8; l++) begin
                    mg = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pool[$urandom_range(0, 3)];
                    d[l*32 +: 32]  = {mg, 16'($urandom)};
                    bv[l*4 +: 4]   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
                end
                send_beat(8'($urandom), 24'($urandom), $urandom, d, bv, (b == nbeats - 1), 1'b1);
            end
        end
        wait_drain("drain_rand");
        rdy_mode = 0;

`ifdef SIG_SCAN_STATS_EN
        check("final_stat_pkts",    256'(stat_pkts), 256'(32'(m_pkts)));
        check("final_stat_matches", 256'(stat_matches), 256'(32'(m_matches)));
`endif
        check("final_idle_rdy", 256'(scn_rdy_dpt), 256'(1'b1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
